// File: rtl/im_loader_if.sv
// Loader-side bus: host handshake in, instruction memory write port
// and cpu control/status out.
interface im_loader_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int DEPTH            = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                        im_loader_start;
    logic [INSTRUCTION_SIZE-1:0] im_loader_in_data;
    logic                        im_loader_in_valid;
    logic                        im_loader_in_last;
    logic                        im_loader_in_ready;
    logic                        im_loader_im_we;
    logic [WORDSIZE-1:0]         im_loader_im_addr;
    logic [INSTRUCTION_SIZE-1:0] im_loader_im_data;
    logic                        im_loader_cpu_hold;
    logic                        im_loader_done;
    logic                        im_loader_full;
    logic [CW-1:0]               im_loader_count;
    logic                        im_loader_err;

    modport master (
        output im_loader_start,
        output im_loader_in_data,
        output im_loader_in_valid,
        output im_loader_in_last,
        input  im_loader_in_ready,
        input  im_loader_im_we,
        input  im_loader_im_addr,
        input  im_loader_im_data,
        input  im_loader_cpu_hold,
        input  im_loader_done,
        input  im_loader_full,
        input  im_loader_count,
        input  im_loader_err
    );

    modport slave (
        input  im_loader_start,
        input  im_loader_in_data,
        input  im_loader_in_valid,
        input  im_loader_in_last,
        output im_loader_in_ready,
        output im_loader_im_we,
        output im_loader_im_addr,
        output im_loader_im_data,
        output im_loader_cpu_hold,
        output im_loader_done,
        output im_loader_full,
        output im_loader_count,
        output im_loader_err
    );
endinterface

// File: rtl/im_loader.sv
// Streams instruction words into IMEM and holds the cpu until loaded.
// Define IM_LOADER_CHECKSUM_EN to add a trailing checksum word check.
module im_loader #(
    parameter int                  WORDSIZE         = 64,
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter int                  DEPTH            = 256,
    parameter logic [WORDSIZE-1:0] BASE_ADDR        = '0
) (
    input logic        im_loader_clk,
    input logic        im_loader_rst_n,
    im_loader_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

`ifdef IM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_LOAD, S_DONE
    } state_t;
`endif

    state_t                      r_state;
    state_t                      w_next;
    logic                        r_we;
    logic [WORDSIZE-1:0]         r_addr;
    logic [INSTRUCTION_SIZE-1:0] r_data;
    logic [CW-1:0]               r_count;
    logic                        r_full;

    logic w_accept;
    logic w_at_depth;
    logic w_end;
    logic w_restart;

    assign w_accept   = bus.im_loader_in_valid && (r_state == S_LOAD);
    assign w_at_depth = (r_count == CW'(DEPTH - 1));
    assign w_end      = w_accept && (bus.im_loader_in_last || w_at_depth);
    assign w_restart  = bus.im_loader_start && (r_state != S_LOAD)
`ifdef IM_LOADER_CHECKSUM_EN
                        && (r_state != S_CSUM)
`endif
                        ;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [INSTRUCTION_SIZE-1:0] r_sum;
    logic                        w_sum_ok;
    assign w_sum_ok = (bus.im_loader_in_data == r_sum);
`endif

    always_ff @(posedge im_loader_clk or negedge im_loader_rst_n) begin
        if (!im_loader_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.im_loader_start) w_next = S_LOAD;
            end
            S_LOAD: begin
`ifdef IM_LOADER_CHECKSUM_EN
                if (w_end) w_next = S_CSUM;
`else
                if (w_end) w_next = S_DONE;
`endif
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (bus.im_loader_in_valid)
                    w_next = w_sum_ok ? S_DONE : S_ERR;
            end
            S_ERR: begin
                if (bus.im_loader_start) w_next = S_LOAD;
            end
`endif
            S_DONE: begin
                if (bus.im_loader_start) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Write port is registered: word k lands one cycle after acceptance.
    always_ff @(posedge im_loader_clk or negedge im_loader_rst_n) begin
        if (!im_loader_rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_data  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_restart) begin
                r_count <= '0;
                r_full  <= 1'b0;
            end else if (w_accept) begin
                r_addr  <= BASE_ADDR + (WORDSIZE'(r_count) << 2);
                r_data  <= bus.im_loader_in_data;
                r_count <= r_count + 1'b1;
                if (w_at_depth && !bus.im_loader_in_last)
                    r_full <= 1'b1;
            end
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    always_ff @(posedge im_loader_clk or negedge im_loader_rst_n) begin
        if (!im_loader_rst_n) begin
            r_sum <= '0;
        end else if (w_restart) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + bus.im_loader_in_data;
        end
    end

    assign bus.im_loader_in_ready = (r_state == S_LOAD)
                                 || (r_state == S_CSUM);
    assign bus.im_loader_err      = (r_state == S_ERR);
`else
    assign bus.im_loader_in_ready = (r_state == S_LOAD);
    assign bus.im_loader_err      = 1'b0;
`endif

    assign bus.im_loader_im_we    = r_we;
    assign bus.im_loader_im_addr  = r_addr;
    assign bus.im_loader_im_data  = r_data;
    assign bus.im_loader_cpu_hold = (r_state != S_DONE);
    assign bus.im_loader_done     = (r_state == S_DONE);
    assign bus.im_loader_full     = r_full;
    assign bus.im_loader_count    = r_count;
endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: randomized loads against a
// transaction-level model; a monitor checks every IMEM write.
module tb_im_loader;
    localparam int          WS    = 64;
    localparam int          IS    = 32;
    localparam int          DEPTH = 4;
    localparam logic [63:0] BASE  = 64'hFFFF_FFFF_FFFF_FFF8;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_CSUM = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    im_loader_if #(.WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .DEPTH(DEPTH)) bus ();

    im_loader #(
        .WORDSIZE(WS), .INSTRUCTION_SIZE(IS),
        .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .im_loader_clk  (clk),
        .im_loader_rst_n(rst_n),
        .bus            (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          cnt;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] src[$];
    int          checks = 0;
    int          errors = 0;
    int          m_st   = M_IDLE;
    int          m_cnt  = 0;
    bit          m_full = 1'b0;
    logic [31:0] m_sum  = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what one clock edge does to the loader, by the rules.
    task automatic model_edge(bit s, bit v, bit l, logic [31:0] d);
        case (m_st)
            M_IDLE, M_DONE, M_ERR: begin
                if (s) begin
                    m_st = M_LOAD; m_cnt = 0; m_full = 0; m_sum = '0;
                end
            end
            M_LOAD: begin
                if (v) begin
                    exp_q.push_back('{BASE + 64'(4 * m_cnt), d, m_cnt + 1});
                    m_sum += d;
                    m_cnt++;
                    if (l || m_cnt == DEPTH) begin
                        m_full = !l;
                        m_st   = CS ? M_CSUM : M_DONE;
                    end
                end
            end
            M_CSUM: begin
                if (v) m_st = (d == m_sum) ? M_DONE : M_ERR;
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic check_status();
        chk("in_ready", 64'(bus.im_loader_in_ready),
            64'(m_st == M_LOAD || m_st == M_CSUM));
        chk("cpu_hold", 64'(bus.im_loader_cpu_hold), 64'(m_st != M_DONE));
        chk("done", 64'(bus.im_loader_done), 64'(m_st == M_DONE));
        chk("err", 64'(bus.im_loader_err), 64'(m_st == M_ERR));
        chk("full", 64'(bus.im_loader_full), 64'(m_full));
        chk("count", 64'(bus.im_loader_count), 64'(m_cnt));
    endtask

    task automatic step(bit s, bit v, bit l, logic [31:0] d);
        bus.im_loader_start    = s;
        bus.im_loader_in_valid = v;
        bus.im_loader_in_last  = l;
        bus.im_loader_in_data  = d;
        model_edge(s, v, l, d);
        @(posedge clk);
        @(negedge clk);
        check_status();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
    endtask

    // vmode: 0 random valid (vpct %), 1 always, 2 toggle 1/0
    task automatic run_load(int n, int last_at, int vmode, int vpct, bit good);
        int          offered = 0;
        int          budget  = 300;
        int          cyc     = 0;
        bit          v;
        bit          s;
        logic [31:0] d;
        step(1'b1, 1'b0, 1'b0, '0);
        while (offered < n && budget > 0) begin
            budget--;
            case (vmode)
                1:       v = 1'b1;
                2:       v = (cyc % 2) == 0;
                default: v = $urandom_range(99) < vpct;
            endcase
            cyc++;
            s = (vmode == 0) && (m_st == M_LOAD) && ($urandom_range(7) == 0);
            if (!v) begin
                step(s, 1'b0, 1'($urandom_range(1)), $urandom);
            end else if (m_st == M_CSUM) begin
                step(s, 1'b1, 1'($urandom_range(1)), good ? m_sum : m_sum + 32'd7);
            end else begin
                d = (src.size() > 0) ? src.pop_front() : $urandom;
                step(s, 1'b1, offered == last_at, d);
                offered++;
            end
        end
        while (m_st == M_CSUM && budget > 0) begin
            budget--;
            step(1'b0, 1'b1, 1'b0, good ? m_sum : m_sum ^ 32'h8000_0001);
        end
        chk("load_budget", 64'(budget > 0), 64'(1));
        src.delete();
        idle(2);
    endtask

    always begin
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.im_loader_im_we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_we", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("im_addr", bus.im_loader_im_addr, e.addr);
                chk("im_data", 64'(bus.im_loader_im_data), 64'(e.data));
                chk("wr_count", 64'(bus.im_loader_count), 64'(e.cnt));
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_we", 64'(bus.im_loader_im_we), 64'(0));
        chk("rst_addr", bus.im_loader_im_addr, BASE);
        chk("rst_data", 64'(bus.im_loader_im_data), 64'(0));
        check_status();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bus.im_loader_start    = 1'b0;
        bus.im_loader_in_valid = 1'b0;
        bus.im_loader_in_last  = 1'b0;
        bus.im_loader_in_data  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        idle(2);

        src = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        run_load(3, 2, 1, 100, 1'b1);

        run_load(4, 3, 2, 100, 1'b1);

        run_load(6, -1, 1, 100, 1'b1);

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 32'h1111_1111);
        step(1'b0, 1'b1, 1'b0, 32'h2222_2222);
        #2 rst_n = 1'b0;
        m_st = M_IDLE; m_cnt = 0; m_full = 0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_load(5, 4, 1, 100, 1'b1);

        src = '{32'hDEAD_BEEF};
        run_load(1, 0, 1, 100, 1'b1);

        src = '{32'h1, 32'h2};
        run_load(2, 1, 1, 100, 1'b1);
        src = '{32'h1, 32'h2};
        run_load(2, 1, 1, 100, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int n;
            n = $urandom_range(1, 6);
            run_load(n, $urandom_range(0, n), 0,
                     $urandom_range(30, 100), 1'($urandom_range(1)));
        end

        idle(3);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Program loader: the write-side counterpart of the CPU observation path. It streams instruction words into the instruction memory write port before execution.
- Accepts 32-bit words over a valid/ready handshake and writes them to consecutive byte addresses (stride 4) from BASE_ADDR.
- Holds the cpu in reset until the load completes, then releases it.
- Sits between the bench or host link and the cpu top level.

Parameters:
WORDSIZE, 64, width of address bus (matches pc address width)
INSTRUCTION_SIZE, 32, width of instruction word
DEPTH, 256, maximum number of instruction words loadable
BASE_ADDR, 0, byte address of first written word

Ports:
im_loader_clk  input  1  clock, rising-edge
im_loader_rst_n  input  1  asynchronous active-low reset
im_loader_start  input  1  one-cycle pulse; begins a load
im_loader_in_data  input  INSTRUCTION_SIZE  incoming instruction word
im_loader_in_valid  input  1  in_data valid
im_loader_in_last  input  1  marks final data word of program
im_loader_in_ready  output  1  loader can accept a word this cycle
im_loader_im_we  output  1  instruction memory write enable
im_loader_im_addr  output  WORDSIZE  instruction memory byte address
im_loader_im_data  output  INSTRUCTION_SIZE  instruction memory write data
im_loader_cpu_hold  output  1  1 = cpu held in reset
im_loader_done  output  1  load complete, cpu running
im_loader_full  output  1  load ended by reaching DEPTH without last
im_loader_count  output  clog2(DEPTH)+1  words written in current load
im_loader_err  output  1  checksum mismatch (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE, cpu_hold=1
  - in_ready=0, im_we=0, im_addr=BASE_ADDR, im_data=0
  - done=0, full=0, count=0, err=0
- Reset mid-load abandons the load. Words already written stay in memory; the loader holds no memory state.
- States:
  - IDLE: cpu_hold=1, in_ready=0. start -> LOAD.
  - LOAD: in_ready=1. A word is accepted when in_valid and in_ready are both high at a rising edge.
  - DONE: cpu_hold=0, done=1, in_ready=0. start -> LOAD.
  - ERR: checksum build only; cpu_hold=1, err=1. start -> LOAD.
- Entering LOAD (from IDLE, DONE or ERR):
  - count cleared, write address reset to BASE_ADDR
  - cpu_hold=1, done=0, full=0, err=0
- Write timing, per accepted word k (0-based):
  - Cycle after acceptance: im_we=1 for exactly one cycle, im_addr=BASE_ADDR+4*k (WORDSIZE arithmetic, wraps modulo 2^WORDSIZE), im_data=word.
  - count increments in the same cycle that im_we is asserted.
- Back-to-back acceptance is allowed: one word per cycle, im_we high continuously.
- End of load:
  - The word accepted with in_last=1 is the final data word.
  - Accepting word index DEPTH-1 with in_last=0 also ends the load and sets full=1.
  - In both cases in_ready drops the cycle after that acceptance. The state moves to DONE the same edge the final im_we pulse is driven; done and cpu_hold change together with that pulse.
- start while in LOAD is ignored.
- in_valid outside LOAD is ignored; no words are accepted.
- im_addr and im_data hold their last values when im_we=0.

Optional Feature:
IM_LOADER_CHECKSUM_EN
- Defined:
  - After the last or DEPTH-th data word, LOAD accepts exactly one extra word: the checksum.
  - The checksum is compared against the modulo-2^32 sum of all data words of this load. It is never written to memory (no im_we).
  - Match -> DONE.
  - Mismatch -> ERR: err=1, cpu_hold=1, done=0, until start or reset.
  - in_last on the checksum word is don't-care.
- Undefined: no checksum phase, ERR state absent, err tied 0.

Test Plan:
- Reset, then start, then 3 words 0x00500093, 0x00A00113, 0x002081B3 (last on 3rd), valid every cycle -> im_we pulses at addrs 0x0, 0x4, 0x8 on consecutive cycles; count=3; cpu_hold falls and done rises with the 3rd write; full=0.
- Load with in_valid toggled 1/0 every cycle, 4 words, BASE_ADDR=0x1000 -> writes at 0x1000, 0x1004, 0x1008, 0x100C only on accept-plus-1 cycles; no extra im_we.
- DEPTH=4, 6 words offered with no last -> only 4 written; full=1, done=1; in_ready=0 after the 4th acceptance; words 5-6 ignored.
- Assert rst_n=0 after the 2nd word of a 5-word load -> all outputs go to reset values immediately (async); cpu_hold=1. A new start reloads from BASE_ADDR with count restarting at 0.
- From DONE, pulse start, then 1 word 0xDEADBEEF with last -> cpu_hold reasserts the cycle after start; write at BASE_ADDR; done again; count=1.
- IM_LOADER_CHECKSUM_EN defined:
  - Words 0x1, 0x2 (last), then checksum 0x3 -> DONE, err=0, no write for checksum.
  - Same load with checksum 0x4 -> ERR, err=1, cpu_hold=1.
